// File: rtl/gshare_bp.sv
// Gshare direction predictor with a direct-mapped BTB. Lookup is combinational; training lands one cycle after upd_valid.
// No backpressure: one update per cycle is accepted, and updates during reset or INIT are dropped.
module gshare_bp #(
  parameter int DBITS   = 32,
  parameter int BPBITS  = 8,
  parameter int BTBBITS = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DBITS-1:0]  fe_pc,
  output logic              pred_taken,
  output logic [DBITS-1:0]  pred_target,
  output logic [BPBITS-1:0] pred_idx,
  input  logic              upd_valid,
  input  logic              upd_dir,
  input  logic [BPBITS-1:0] upd_idx,
  input  logic [DBITS-1:0]  upd_target,
  input  logic [DBITS-1:0]  upd_pc,
  output logic              init_busy
);
  localparam int TBITS = DBITS - BTBBITS - 2;

  typedef struct packed {
    logic             valid;
    logic [TBITS-1:0] tag;
    logic [DBITS-1:0] target;
  } btb_entry_t;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [BPBITS-1:0] init_cnt;
  logic [BPBITS-1:0] ghr;
  logic [1:0]        bht [2**BPBITS];
  btb_entry_t        btb [2**BTBBITS];

  logic [BTBBITS-1:0] fe_bi, upd_bi;
  btb_entry_t         fe_ent;
  logic               hit, run;
  logic               unused_pc_lsbs;

  assign unused_pc_lsbs = ^{fe_pc[1:0], upd_pc[1:0]};

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && init_cnt == {BPBITS{1'b1}}) state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= INIT;
      init_cnt <= '0;
      ghr      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) init_cnt <= init_cnt + 1'b1;
      if (state_q == RUN && upd_valid) ghr <= {ghr[BPBITS-2:0], upd_dir};
    end
  end

  // Tables carry no reset term; the INIT walk is what clears them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT) begin
        bht[init_cnt]                  <= 2'b01;
        btb[init_cnt[BTBBITS-1:0]].valid <= 1'b0;
      end else if (upd_valid) begin
        if (upd_dir) begin
          if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'd1;
          btb[upd_bi] <= '{valid: 1'b1, tag: upd_pc[DBITS-1:BTBBITS+2], target: upd_target};
        end else if (bht[upd_idx] != 2'b00) begin
          bht[upd_idx] <= bht[upd_idx] - 2'd1;
        end
      end
    end
  end

  assign run         = (state_q == RUN) && !reset;
  assign init_busy   = !run;
  assign pred_idx    = fe_pc[BPBITS+1:2] ^ ghr;
  assign fe_bi       = fe_pc[BTBBITS+1:2];
  assign upd_bi      = upd_pc[BTBBITS+1:2];
  assign fe_ent      = btb[fe_bi];
  assign hit         = fe_ent.valid && (fe_ent.tag == fe_pc[DBITS-1:BTBBITS+2]);
  assign pred_taken  = run && bht[pred_idx][1] && hit;
  assign pred_target = pred_taken ? fe_ent.target : '0;
endmodule

// File: tb/tb_gshare_bp.sv
// Directed bench for gshare_bp: INIT timing, training, saturation, dropped updates, read-before-write.
module tb_gshare_bp;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fe_pc = 32'h100;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [7:0]  pred_idx;
  logic        upd_valid = 1'b0;
  logic        upd_dir = 1'b0;
  logic [7:0]  upd_idx = 8'h00;
  logic [31:0] upd_target = 32'h0;
  logic [31:0] upd_pc = 32'h0;
  logic        init_busy;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc, seen;
  logic [7:0] ghr_m = 8'h00;

  gshare_bp dut (
    .clk(clk), .reset(reset), .fe_pc(fe_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_idx(pred_idx),
    .upd_valid(upd_valid), .upd_dir(upd_dir), .upd_idx(upd_idx),
    .upd_target(upd_target), .upd_pc(upd_pc), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Presents one update for one clock, then returns half a cycle later.
  task automatic upd(input logic dir, input logic [7:0] idx, input logic [31:0] pc,
                     input logic [31:0] tgt);
    upd_valid = 1'b1; upd_dir = dir; upd_idx = idx; upd_pc = pc; upd_target = tgt;
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    ghr_m = {ghr_m[6:0], dir};
  endtask

  // Counts busy cycles after reset release; optionally injects a taken update at one INIT cycle.
  task automatic wait_init(input int inject_at, output int n, output int taken_seen);
    n = 0;
    taken_seen = 0;
    while (init_busy && n < 600) begin
      if (pred_taken) taken_seen++;
      upd_valid  = (n == inject_at);
      upd_dir    = 1'b1;
      upd_idx    = 8'h03;
      upd_pc     = 32'h100;
      upd_target = 32'h200;
      n++;
      @(negedge clk);
      #1;
    end
    upd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    reset = 1'b1;
    fe_pc = 32'h100;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy",   32'(init_busy),   32'h1);
    check("rst_taken",  32'(pred_taken),  32'h0);
    check("rst_target", pred_target,      32'h0);
    check("rst_idx",    32'(pred_idx),    32'h40);

    // INIT length, no prediction during INIT, update at INIT cycle 10 dropped
    reset = 1'b0;
    wait_init(10, cyc, seen);
    check("init_len",       cyc,                    32'd256);
    check("init_no_taken",  seen,                   32'd0);
    check("init_upd_ghr",   32'(dut.ghr),           32'h0);
    check("init_upd_bht",   32'(dut.bht[3]),        32'h1);
    check("init_upd_btb",   32'(dut.btb[0].valid),  32'h0);
    check("init_busy_done", 32'(init_busy),         32'h0);
    check("post_init_pred", 32'(pred_taken),        32'h0);

    // Reset in the middle of INIT restarts the walk
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    reset = 1'b1;
    check("midinit_rst_busy", 32'(init_busy), 32'h1);
    @(negedge clk); #1;
    reset = 1'b0;
    wait_init(-1, cyc, seen);
    check("reinit_len", cyc, 32'd256);
    ghr_m = 8'h00;

    // First training: taken branch at 0x100
    upd(1'b1, 8'h41, 32'h100, 32'h200);
    check("t2_ghr", 32'(dut.ghr), 32'(ghr_m));
    fe_pc = 32'h100; #1;
    check("t2_idx",    32'(pred_idx),   32'h41);
    check("t2_taken",  32'(pred_taken), 32'h1);
    check("t2_target", pred_target,     32'h200);
    fe_pc = 32'h500; #1;
    check("tag_miss_taken",  32'(pred_taken), 32'h0);
    check("tag_miss_target", pred_target,     32'h0);

    // Saturation at idx 0x10
    fe_pc = 32'h100;
    repeat (3) upd(1'b0, 8'h10, 32'h100, 32'hDEAD0);
    check("sat_low",      32'(dut.bht[8'h10]),     32'h0);
    check("nt_no_btb",    dut.btb[0].target,       32'h200);
    repeat (5) upd(1'b1, 8'h10, 32'h10C, 32'h400);
    check("sat_high",     32'(dut.bht[8'h10]),     32'h3);
    upd(1'b0, 8'h10, 32'h10C, 32'hDEAD0);
    check("sat_high_dec", 32'(dut.bht[8'h10]),     32'h2);

    // Read-before-write: BHT[0x41]=01, GHR=0x01, BTB hit for 0x100 and 0x108
    upd(1'b0, 8'h41, 32'h100, 32'hDEAD0);
    repeat (7) upd(1'b0, 8'h10, 32'h100, 32'hDEAD0);
    upd(1'b1, 8'h20, 32'h108, 32'h300);
    check("rbw_ghr_setup", 32'(dut.ghr),       32'h01);
    check("rbw_bht_setup", 32'(dut.bht[8'h41]), 32'h1);
    fe_pc      = 32'h100;
    upd_valid  = 1'b1; upd_dir = 1'b1; upd_idx = 8'h41;
    upd_pc     = 32'h100; upd_target = 32'h200;
    #1;
    check("rbw_idx",    32'(pred_idx),   32'h41);
    check("rbw_taken",  32'(pred_taken), 32'h0);
    check("rbw_target", pred_target,     32'h0);
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    check("rbw_bht_after", 32'(dut.bht[8'h41]), 32'h2);
    check("rbw_ghr_after", 32'(dut.ghr),        32'h03);
    fe_pc = 32'h108; #1;
    check("rbw_next_idx",    32'(pred_idx),   32'h41);
    check("rbw_next_taken",  32'(pred_taken), 32'h1);
    check("rbw_next_target", pred_target,     32'h300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
